// File: rtl/hash_hit_collector.sv
// Collects the two per-beat hash-hit lanes, tags them with byte positions, and serialises
// them (plus an end-of-packet marker) into a show-ahead valid/ready record stream.
module hash_hit_collector #(
   parameter int DWIDTH    = 16,
   parameter int POS_W     = 16,
   parameter int FIFO_AW   = 5,
   parameter int AF_MARGIN = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_beat,
   input  logic              in_last,
   input  logic [DWIDTH-1:0] in_hash0,
   input  logic              in_hit0,
   input  logic [DWIDTH-1:0] in_hash1,
   input  logic              in_hit1,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DWIDTH-1:0] out_hash,
   output logic [POS_W-1:0]  out_pos,
   output logic              out_lane,
   output logic              out_last,
   output logic              out_empty,
   output logic              almost_full,
   output logic              overflow,
   output logic [15:0]       drop_cnt
);

   localparam int DEPTH  = 1 << FIFO_AW;
   localparam int REC_W  = DWIDTH + POS_W + 3;
   localparam int CNT_W  = FIFO_AW + 1;
   localparam int FREE_W = FIFO_AW + 2;
   localparam int NWR    = 3;

   // Beat counter only needs POS_W-1 bits: positions are 2*bc and 2*bc+1.
   logic [POS_W-2:0]  bc_q, bc_d;

   logic              s1_hit0_q, s1_hit1_q, s1_last_q;
   logic [DWIDTH-1:0] s1_hash0_q, s1_hash1_q;
   logic [POS_W-2:0]  s1_bc_q;

   logic [REC_W-1:0]  mem_q [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  mem_cnt_q, mem_cnt_d;

   logic              out_valid_q, out_valid_d;
   logic [REC_W-1:0]  out_rec_q, out_rec_d;
   logic              overflow_q, overflow_d;
   logic [15:0]       drop_cnt_q, drop_cnt_d;

   logic              pop;
   logic              load;
   logic [FREE_W-1:0] occ;
   logic [FREE_W-1:0] free_now;
   logic [FREE_W-1:0] free_avail;
   logic [FREE_W-1:0] need;
   logic [1:0]        n_hits;
   logic [1:0]        n_wr;
   logic [1:0]        n_drop;
   logic              hits_ok;
   logic              mark_ok;
   logic [REC_W-1:0]  rec_h0, rec_h1, rec_mk;
   logic [REC_W-1:0]  wr_rec  [NWR];
   logic [FIFO_AW-1:0] wr_addr [NWR];
   logic [NWR-1:0]    wr_en;
   logic [16:0]       drop_sum;

   // Output register counts as one of the DEPTH slots, so total capacity is DEPTH records.
   assign pop        = out_valid_q & out_ready;
   assign occ        = FREE_W'(mem_cnt_q) + FREE_W'(out_valid_q);
   assign free_now   = FREE_W'(DEPTH) - occ;
   assign free_avail = free_now + FREE_W'(pop);
   assign n_hits     = {1'b0, s1_hit0_q} + {1'b0, s1_hit1_q};
   assign need       = FREE_W'(n_hits) + FREE_W'(s1_last_q);
   assign hits_ok    = (need <= free_avail);
   assign mark_ok    = s1_last_q & (free_avail != '0);

   assign rec_h0 = {s1_hash0_q, s1_bc_q, 1'b0, 3'b000};
   assign rec_h1 = {s1_hash1_q, s1_bc_q, 1'b1, 3'b100};
   assign rec_mk = {{DWIDTH{1'b0}}, s1_bc_q, 1'b1, 3'b111};

   // Compact the accepted records of the staged beat into consecutive write slots.
   always_comb begin
      for (int k = 0; k < NWR; k++) begin
         wr_rec[k] = '0;
      end
      n_wr   = '0;
      n_drop = '0;
      if (hits_ok) begin
         if (s1_hit0_q) begin
            wr_rec[n_wr] = rec_h0;
            n_wr         = n_wr + 2'd1;
         end
         if (s1_hit1_q) begin
            wr_rec[n_wr] = rec_h1;
            n_wr         = n_wr + 2'd1;
         end
      end else begin
         n_drop = n_hits + {1'b0, s1_last_q & ~mark_ok};
      end
      if (mark_ok) begin
         wr_rec[n_wr] = rec_mk;
         n_wr         = n_wr + 2'd1;
      end
   end

   generate
      for (genvar gi = 0; gi < NWR; gi++) begin : g_wr_port
         assign wr_addr[gi] = wr_ptr_q + FIFO_AW'(gi);
         assign wr_en[gi]   = (n_wr > 2'(gi));
      end
   endgenerate

   always_ff @(posedge clk) begin
      for (int k = 0; k < NWR; k++) begin
         if (wr_en[k]) begin
            mem_q[wr_addr[k]] <= wr_rec[k];
         end
      end
   end

   // Show-ahead output: refill the output register whenever it is empty or being popped.
   always_comb begin
      load        = (mem_cnt_q != '0) & (~out_valid_q | pop);
      out_valid_d = out_valid_q;
      out_rec_d   = out_rec_q;
      if (load) begin
         out_valid_d = 1'b1;
         out_rec_d   = mem_q[rd_ptr_q];
      end else if (pop) begin
         out_valid_d = 1'b0;
      end
      rd_ptr_d  = rd_ptr_q + FIFO_AW'(load);
      wr_ptr_d  = wr_ptr_q + FIFO_AW'(n_wr);
      mem_cnt_d = mem_cnt_q + CNT_W'(n_wr) - CNT_W'(load);
   end

   always_comb begin
      bc_d = bc_q;
      if (in_beat) begin
         bc_d = in_last ? '0 : bc_q + 1'b1;
      end
      overflow_d = overflow_q | ~hits_ok;
      drop_sum   = {1'b0, drop_cnt_q} + 17'(n_drop);
      drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bc_q        <= '0;
         s1_hit0_q   <= 1'b0;
         s1_hit1_q   <= 1'b0;
         s1_last_q   <= 1'b0;
         s1_hash0_q  <= '0;
         s1_hash1_q  <= '0;
         s1_bc_q     <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         mem_cnt_q   <= '0;
         out_valid_q <= 1'b0;
         out_rec_q   <= '0;
         overflow_q  <= 1'b0;
         drop_cnt_q  <= '0;
      end else begin
         bc_q        <= bc_d;
         s1_hit0_q   <= in_beat & in_hit0;
         s1_hit1_q   <= in_beat & in_hit1;
         s1_last_q   <= in_beat & in_last;
         if (in_beat) begin
            s1_hash0_q <= in_hash0;
            s1_hash1_q <= in_hash1;
            s1_bc_q    <= bc_q;
         end
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         mem_cnt_q   <= mem_cnt_d;
         out_valid_q <= out_valid_d;
         out_rec_q   <= out_rec_d;
         overflow_q  <= overflow_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_hash    = out_rec_q[REC_W-1 -: DWIDTH];
   assign out_pos     = out_rec_q[POS_W+2:3];
   assign out_lane    = out_rec_q[2];
   assign out_last    = out_rec_q[1];
   assign out_empty   = out_rec_q[0];
   assign almost_full = (free_now <= FREE_W'(AF_MARGIN));
   assign overflow    = overflow_q;
   assign drop_cnt    = drop_cnt_q;

endmodule
